// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: expands one host register access into the byte-level I2C
// master's order sequence and returns a single response beat.
//
//   write: START, WR(reg), WR(wdata), STOP
//   read : START, WR(reg), RESTART, RD, STOP
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        host request handshake
//   req_rw/dev/reg/wdata       request fields (latched on accept)
//   rsp_valid/rsp_rdata/err    one-cycle response beat; rdata/err held until next accept
//   m_order/m_wr_enable        order code and one-cycle command strobe to the master
//   m_addr/m_data_in           slave address and transmit byte to the master
//   m_rd_data/m_ready/m_done/m_finish   master status inputs
//
// Handshakes: a request transfers on a rising clk edge where
// req_valid && req_ready; req_ready is high only in IDLE. An order
// transfers to the master on an edge where m_wr_enable is high, which only
// happens while m_ready is high.
//
// Optional feature: define I2C_REG_SEQ_TIMEOUT_EN to build the per-step
// timer and abort path (TIMEOUT_CYCLES). Without it every step waits
// indefinitely and rsp_err is tied low.
module i2c_reg_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [2:0] m_order,
  output logic       m_wr_enable,
  output logic [6:0] m_addr,
  output logic [7:0] m_data_in,
  input  logic [7:0] m_rd_data,
  input  logic       m_ready,
  input  logic       m_done,
  input  logic       m_finish
);

  localparam logic [2:0] ORD_START   = 3'd0;
  localparam logic [2:0] ORD_WR      = 3'd1;
  localparam logic [2:0] ORD_RD      = 3'd2;
  localparam logic [2:0] ORD_STOP    = 3'd3;
  localparam logic [2:0] ORD_RESTART = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       armed_q;       // holds req_ready low until the first edge after reset
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;
  logic       busy_seen_q;
  logic [7:0] rdata_q;

  logic       accept, is_stop, step_done, timeout, abort;
  logic [2:0] cur_order, stop_step;
  logic [7:0] cur_data;

  assign accept    = req_valid && req_ready;
  assign is_stop   = (cur_order == ORD_STOP);
  assign stop_step = rw_q ? 3'd4 : 3'd3;

  // Order and payload for the current step.
  always_comb begin
    cur_order = ORD_START;
    cur_data  = 8'h00;
    case (step_q)
      3'd0: cur_order = ORD_START;
      3'd1: begin
        cur_order = ORD_WR;
        cur_data  = reg_q;
      end
      3'd2: begin
        cur_order = rw_q ? ORD_RESTART : ORD_WR;
        cur_data  = rw_q ? 8'h00 : wdata_q;
      end
      3'd3: cur_order = rw_q ? ORD_RD : ORD_STOP;
      default: cur_order = ORD_STOP;
    endcase
  end

  // START/RESTART completion needs the master to go busy and come back,
  // otherwise a still-high m_ready right after the strobe would look done.
  always_comb begin
    step_done = 1'b0;
    if (state_q == S_WAIT) begin
      case (cur_order)
        ORD_START, ORD_RESTART: step_done = busy_seen_q && m_ready;
        ORD_WR, ORD_RD:         step_done = m_done;
        default:                step_done = m_finish;
      endcase
    end
  end

  // A timeout only aborts if the step did not complete or get issued on the
  // same cycle.
  assign abort = timeout && (((state_q == S_ISSUE) && !m_ready) ||
                             ((state_q == S_WAIT) && !step_done));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          step_d  = 3'd0;
        end
      end
      S_ISSUE: begin
        if (m_ready) begin
          state_d = S_WAIT;
        end else if (abort) begin
          if (is_stop) state_d = S_RESP;
          else         step_d  = stop_step;
        end
      end
      S_WAIT: begin
        if (step_done) begin
          if (is_stop) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
            step_d  = step_q + 3'd1;
          end
        end else if (abort) begin
          if (is_stop) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
            step_d  = stop_step;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready   = armed_q && (state_q == S_IDLE);
    m_wr_enable = (state_q == S_ISSUE) && m_ready;
    m_order     = cur_order;
    m_data_in   = cur_data;
    m_addr      = dev_q;
    rsp_valid   = (state_q == S_RESP);
    rsp_rdata   = rdata_q;
  end

  // Request latch, busy tracking and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q     <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      busy_seen_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        rw_q    <= req_rw;
        dev_q   <= req_dev;
        reg_q   <= req_reg;
        wdata_q <= req_wdata;
      end
      if (m_wr_enable) busy_seen_q <= 1'b0;
      else if ((state_q == S_WAIT) && !m_ready) busy_seen_q <= 1'b1;
      // Aborted reads report zero even if the RD byte had already arrived.
      if (accept || abort) rdata_q <= 8'h00;
      else if ((state_q == S_WAIT) && (cur_order == ORD_RD) && m_done) rdata_q <= m_rd_data;
    end
  end

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  logic [15:0] timer_q, timer_inc;
  logic        err_q;

  assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
  assign timeout   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                     (32'(timer_inc) >= TIMEOUT_CYCLES);

  // The timer restarts on every state or step change, so it measures time
  // spent on one step (issue wait, then completion wait after the strobe).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      if ((state_d != state_q) || (step_d != step_q)) timer_q <= 16'h0000;
      else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) timer_q <= timer_inc;
      if (accept)     err_q <= 1'b0;
      else if (abort) err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign rsp_err            = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_i2c_reg_seq.sv
module tb_i2c_reg_seq;

  localparam logic [2:0] ORD_START   = 3'd0;
  localparam logic [2:0] ORD_WR      = 3'd1;
  localparam logic [2:0] ORD_RD      = 3'd2;
  localparam logic [2:0] ORD_STOP    = 3'd3;
  localparam logic [2:0] ORD_RESTART = 3'd4;

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] regi;
    logic [7:0] wdata;
    logic [7:0] rd_val;
    int         bp;
    bit         drop_wr;
    bit         drop_fin;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       reset;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [2:0] m_order;
  logic       m_wr_enable;
  logic [6:0] m_addr;
  logic [7:0] m_data_in, m_rd_data;
  logic       m_ready, m_done, m_finish;
  logic       mdl_done, mdl_finish, spur_done, spur_fin;

  assign m_done   = mdl_done | spur_done;
  assign m_finish = mdl_finish | spur_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_reg_seq #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_order(m_order), .m_wr_enable(m_wr_enable), .m_addr(m_addr),
    .m_data_in(m_data_in), .m_rd_data(m_rd_data), .m_ready(m_ready),
    .m_done(m_done), .m_finish(m_finish)
  );

  // ---------------- master model ----------------
  // Strobe log entry: {m_ready, order, data, addr}
  logic [18:0] obs_q[$];
  int          obs_cyc[$];
  int          mdl_bp = 0;
  logic [7:0]  mdl_rd_val = 8'h00;
  bit          mdl_drop_wr = 0;
  bit          mdl_drop_fin = 0;
  int          mdl_base = 0;
  int          dup_strobes = 0;
  int          ph = 0;

  initial begin
    logic [2:0] ord;
    int cnt, idx;
    ord = 3'd0; cnt = 0; idx = 0;
    m_ready = 1'b1; mdl_done = 1'b0; mdl_finish = 1'b0; m_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        ph = 0; m_ready = 1'b1; mdl_done = 1'b0; mdl_finish = 1'b0;
      end else begin
        case (ph)
          1: begin m_ready = 1'b0; ph = 2; end
          2: begin
            case (ord)
              ORD_START, ORD_RESTART: m_ready = 1'b1;
              ORD_WR: if (!(mdl_drop_wr && idx == 1)) mdl_done = 1'b1;
              ORD_RD: begin m_rd_data = mdl_rd_val; mdl_done = 1'b1; end
              default: if (!mdl_drop_fin) mdl_finish = 1'b1;
            endcase
            ph = 3;
          end
          3: begin
            mdl_done = 1'b0; mdl_finish = 1'b0;
            if (mdl_bp > 0) begin m_ready = 1'b0; cnt = mdl_bp; ph = 4; end
            else begin m_ready = 1'b1; ph = 0; end
          end
          4: begin
            cnt--;
            if (cnt == 0) begin m_ready = 1'b1; ph = 0; end
          end
          default: ;
        endcase
      end
      #1;
      if (ph == 0) begin
        if (m_wr_enable) begin
          idx = obs_q.size() - mdl_base;
          obs_q.push_back({m_ready, m_order, m_data_in, m_addr});
          obs_cyc.push_back(cyc);
          ord = m_order;
          ph = 1;
        end
      end else if (m_wr_enable) begin
        dup_strobes++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] pk(input logic [2:0] o, input logic [7:0] d, input logic [6:0] a);
    return {1'b1, o, d, a};
  endfunction

  function automatic void build_exp(input vec_t v);
    exp_q.delete();
    exp_q.push_back(pk(ORD_START, 8'h00, v.dev));
    exp_q.push_back(pk(ORD_WR, v.regi, v.dev));
    if (v.drop_wr) begin
      exp_q.push_back(pk(ORD_STOP, 8'h00, v.dev));
    end else if (!v.rw) begin
      exp_q.push_back(pk(ORD_WR, v.wdata, v.dev));
      exp_q.push_back(pk(ORD_STOP, 8'h00, v.dev));
    end else begin
      exp_q.push_back(pk(ORD_RESTART, 8'h00, v.dev));
      exp_q.push_back(pk(ORD_RD, 8'h00, v.dev));
      exp_q.push_back(pk(ORD_STOP, 8'h00, v.dev));
    end
  endfunction

  function automatic vec_t mk(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [7:0] wd, input logic [7:0] rv, input int bp,
                              input bit dw, input bit df, input logic [7:0] er, input bit ee);
    vec_t v;
    v.rw = rw; v.dev = dev; v.regi = rg; v.wdata = wd; v.rd_val = rv; v.bp = bp;
    v.drop_wr = dw; v.drop_fin = df; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    bit got;
    got = 0;
    @(negedge clk);
    req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check("req_accept", 32'(got), 32'd1);
    @(negedge clk);
    // Scramble the fields: the DUT must work from its latched copy.
    req_valid = 1'b0; req_rw = ~rw; req_dev = ~dev; req_reg = ~rg; req_wdata = ~wd;
  endtask

  task automatic wait_rsp(output int rc, output bit ok);
    ok = 0; rc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      if (rsp_valid) begin ok = 1; rc = cyc; break; end
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int base, rcyc, dup0, nobs, diff;
    bit ok;
    logic [7:0] rd;
    logic [18:0] a, e;
    mdl_bp = v.bp; mdl_rd_val = v.rd_val; mdl_drop_wr = v.drop_wr; mdl_drop_fin = v.drop_fin;
    base = obs_q.size(); mdl_base = base; dup0 = dup_strobes;
    build_exp(v);
    send_req(v.rw, v.dev, v.regi, v.wdata);
    wait_rsp(rcyc, ok);
    check($sformatf("v%0d rsp_seen", n), 32'(ok), 32'd1);
    if (ok) begin
      rd = rsp_rdata;
      check($sformatf("v%0d rsp_rdata", n), 32'(rsp_rdata), 32'(v.exp_rdata));
      check($sformatf("v%0d rsp_err", n), 32'(rsp_err), 32'(v.exp_err));
      @(negedge clk);
      #2;
      check($sformatf("v%0d rsp_one_cycle", n), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d rdata_held", n), 32'(rsp_rdata), 32'(rd));
    end
    for (int i = 0; i < 100 && ph != 0; i++) @(negedge clk);
    nobs = obs_q.size() - base;
    check($sformatf("v%0d strobe_count", n), 32'(nobs), 32'(exp_q.size()));
    for (int i = 0; i < nobs && i < exp_q.size(); i++) begin
      a = obs_q[base + i];
      e = exp_q[i];
      if (e[17:15] != ORD_WR) a[14:7] = 8'h00;  // payload only defined for WR steps
      check($sformatf("v%0d strobe%0d {rdy,ord,data,addr}", n, i), 32'(a), 32'(e));
    end
    check($sformatf("v%0d extra_strobes", n), 32'(dup_strobes - dup0), 32'd0);
    if (v.drop_wr && nobs >= 3) begin
      diff = obs_cyc[base + 2] - obs_cyc[base + 1];
      check($sformatf("v%0d wr_timeout_cycles=%0d in 100..102", n, diff),
            32'(diff >= 100 && diff <= 102), 32'd1);
    end
    if (v.drop_fin && ok && nobs >= 1) begin
      diff = rcyc - obs_cyc[base + nobs - 1];
      check($sformatf("v%0d stop_timeout_cycles=%0d in 100..102", n, diff),
            32'(diff >= 100 && diff <= 102), 32'd1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"},   32'(req_ready),   32'd0);
    check({tag, " rsp_valid"},   32'(rsp_valid),   32'd0);
    check({tag, " rsp_rdata"},   32'(rsp_rdata),   32'd0);
    check({tag, " rsp_err"},     32'(rsp_err),     32'd0);
    check({tag, " m_order"},     32'(m_order),     32'(ORD_START));
    check({tag, " m_wr_enable"}, 32'(m_wr_enable), 32'd0);
    check({tag, " m_addr"},      32'(m_addr),      32'd0);
    check({tag, " m_data_in"},   32'(m_data_in),   32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_low_before_first_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, accepts, rsps;
    int acc_cyc[2];
    int rsp_cyc[2];
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_dev = 7'h00;
    req_reg = 8'h00; req_wdata = 8'h00; spur_done = 1'b0; spur_fin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    release_reset();

    vecs.push_back(mk(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0,  0, 0, 8'h00, 0));
    vecs.push_back(mk(1'b1, 7'h3C, 8'h07, 8'h00, 8'h5A, 0,  0, 0, 8'h5A, 0));
    vecs.push_back(mk(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 20, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1'b1, 7'h3C, 8'h07, 8'h00, 8'h5A, 20, 0, 0, 8'h5A, 0));
    vecs.push_back(mk(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0));
    vecs.push_back(mk(1'b0, 7'h00, 8'h00, 8'hFF, 8'h00, 3,  0, 0, 8'h00, 0));
    vecs.push_back(mk(1'b1, 7'h01, 8'h80, 8'h00, 8'h81, 1,  0, 0, 8'h81, 0));
`ifdef I2C_REG_SEQ_TIMEOUT_EN
    vecs.push_back(mk(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0,  1, 0, 8'h00, 1));
    vecs.push_back(mk(1'b1, 7'h3C, 8'h07, 8'h00, 8'h5A, 0,  1, 0, 8'h00, 1));
    vecs.push_back(mk(1'b1, 7'h3C, 8'h07, 8'h00, 8'h5A, 0,  0, 1, 8'h00, 1));
    vecs.push_back(mk(1'b1, 7'h3C, 8'h07, 8'h00, 8'h66, 0,  0, 0, 8'h66, 0));
`endif
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset asserted while the RD step is waiting for m_done.
    mdl_bp = 0; mdl_rd_val = 8'hC3; mdl_drop_wr = 0; mdl_drop_fin = 0;
    base = obs_q.size(); mdl_base = base;
    send_req(1'b1, 7'h21, 8'h44, 8'h00);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #2;
      if (obs_q.size() - base >= 4) break;
    end
    check("rd_strobe_reached", 32'(obs_q.size() - base), 32'd4);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midread_reset");
    @(negedge clk);
    #1;
    check_reset_vals("midread_reset_held");
    release_reset();
    run_vec(100, mk(1'b0, 7'h2A, 8'h33, 8'h5C, 8'h00, 0, 0, 0, 8'h00, 0));

    // Spurious completion strobes while idle must not start anything.
    base = obs_q.size();
    @(negedge clk);
    spur_done = 1'b1; spur_fin = 1'b1;
    @(negedge clk);
    spur_done = 1'b0; spur_fin = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("spur_no_strobe", 32'(obs_q.size() - base), 32'd0);
    check("spur_still_idle", 32'(req_ready), 32'd1);
    check("spur_no_rsp", 32'(rsp_valid), 32'd0);

    // req_valid held high across two transactions.
    mdl_base = obs_q.size();
    accepts = 0; rsps = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; rsp_cyc[0] = 0; rsp_cyc[1] = 0;
    req_rw = 1'b0; req_dev = 7'h11; req_reg = 8'h22; req_wdata = 8'h33; req_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      #2;
      if (req_valid && req_ready) begin
        if (accepts < 2) acc_cyc[accepts] = cyc;
        accepts++;
      end
      if (rsp_valid) begin
        check("ready_low_during_rsp", 32'(req_ready), 32'd0);
        if (rsps < 2) rsp_cyc[rsps] = cyc;
        rsps++;
        if (rsps == 2) begin req_valid = 1'b0; break; end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("held_valid_accepts", 32'(accepts), 32'd2);
    check("held_valid_rsps", 32'(rsps), 32'd2);
    check("second_accept_after_rsp", 32'(acc_cyc[1] - rsp_cyc[0]), 32'd1);
    for (int i = 0; i < 100 && ph != 0; i++) @(negedge clk);
    check("held_valid_strobes", 32'(obs_q.size() - base), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
